// File: rtl/mem_req_arbiter.sv
// Arbitrates ICache demand, ICache prefetch and LSB requests onto a single-outstanding byte-serial memory port.
// Optional macro MEM_ARB_AGING_EN: prefetch aging so PF cannot starve behind continuous IC/LSB traffic.
module mem_req_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 1,
  parameter int TIMEOUT     = 64,
  parameter int AGE_LIMIT   = 4
) (
  input  logic                             Sys_clk,
  input  logic                             Sys_rst,
  input  logic                             Sys_rdy,
  input  logic                             ICARB_en,
  input  logic [ADDR_WIDTH-1:0]            ICARB_addr,
  output logic                             ARBIC_en,
  output logic [(32<<BLOCK_WIDTH)-1:0]     ARBIC_block,
  input  logic                             PFARB_en,
  input  logic [ADDR_WIDTH-1:0]            PFARB_addr,
  output logic                             ARBPF_en,
  output logic [(32<<BLOCK_WIDTH)-1:0]     ARBPF_block,
  input  logic                             LSBARB_en,
  input  logic                             LSBARB_wr,
  input  logic [2:0]                       LSBARB_len,
  input  logic [ADDR_WIDTH-1:0]            LSBARB_addr,
  input  logic [31:0]                      LSBARB_data,
  output logic                             ARBLSB_r_en,
  output logic                             ARBLSB_w_en,
  output logic [31:0]                      ARBLSB_data,
  output logic                             ARBMC_en,
  output logic                             ARBMC_wr,
  output logic [3:0]                       ARBMC_len,
  output logic [ADDR_WIDTH-1:0]            ARBMC_addr,
  output logic [31:0]                      ARBMC_wdata,
  input  logic                             MCARB_done,
  input  logic [63:0]                      MCARB_rdata,
  output logic                             ARB_err
);

  localparam int         BLK_W     = 32 << BLOCK_WIDTH;
  localparam logic [3:0] BLK_BYTES = 4'(1 << (BLOCK_WIDTH + 2));
  localparam int         TO_W      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {G_NONE = 2'd0, G_IC = 2'd1, G_PF = 2'd2, G_LSB = 2'd3} grant_t;

  state_t          r_state;
  state_t          w_state_nxt;
  grant_t          r_grant;
  grant_t          w_pick;
  logic            r_last_lsb;
  logic [TO_W-1:0] r_tmo;
  logic            w_force_pf;

  // Keep bytes 0..len-1 of the returned data, zero the rest.
  function automatic logic [31:0] lsb_bytes(input logic [3:0] len, input logic [63:0] rdata);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(len)) v[8*i +: 8] = rdata[8*i +: 8];
    end
    return v;
  endfunction

`ifdef MEM_ARB_AGING_EN
  logic [2:0] r_age;

  // Count IC/LSB wins that happen while a prefetch is waiting.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      r_age <= 3'd0;
    end else if (Sys_rdy && r_state == S_IDLE) begin
      if (w_pick == G_PF) begin
        r_age <= 3'd0;
      end else if ((w_pick == G_IC || w_pick == G_LSB) && PFARB_en && r_age != 3'd7) begin
        r_age <= r_age + 3'd1;
      end
    end
  end

  assign w_force_pf = PFARB_en && (r_age >= 3'(AGE_LIMIT));
`else
  assign w_force_pf = 1'b0;
`endif

  // Arbitration: aged PF first, then IC/LSB alternation, PF only when both are idle.
  always_comb begin
    w_pick = G_NONE;
    if (w_force_pf) begin
      w_pick = G_PF;
    end else if (ICARB_en && LSBARB_en) begin
      w_pick = r_last_lsb ? G_IC : G_LSB;
    end else if (ICARB_en) begin
      w_pick = G_IC;
    end else if (LSBARB_en) begin
      w_pick = G_LSB;
    end else if (PFARB_en) begin
      w_pick = G_PF;
    end else begin
      w_pick = G_NONE;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = (w_pick != G_NONE) ? S_ISSUE : S_IDLE;
      S_ISSUE: w_state_nxt = MCARB_done ? S_RESP : S_ISSUE;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, frozen while Sys_rdy is low.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      r_state <= S_IDLE;
    end else if (Sys_rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // Request latching, response routing, timeout tracking.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      r_grant     <= G_NONE;
      r_last_lsb  <= 1'b1;
      r_tmo       <= '0;
      ARBIC_en    <= 1'b0;
      ARBIC_block <= '0;
      ARBPF_en    <= 1'b0;
      ARBPF_block <= '0;
      ARBLSB_r_en <= 1'b0;
      ARBLSB_w_en <= 1'b0;
      ARBLSB_data <= 32'd0;
      ARBMC_en    <= 1'b0;
      ARBMC_wr    <= 1'b0;
      ARBMC_len   <= 4'd0;
      ARBMC_addr  <= '0;
      ARBMC_wdata <= 32'd0;
      ARB_err     <= 1'b0;
    end else if (Sys_rdy) begin
      ARBIC_en    <= 1'b0;
      ARBPF_en    <= 1'b0;
      ARBLSB_r_en <= 1'b0;
      ARBLSB_w_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_grant <= w_pick;
          case (w_pick)
            G_IC: begin
              ARBMC_en    <= 1'b1;
              ARBMC_wr    <= 1'b0;
              ARBMC_len   <= BLK_BYTES;
              ARBMC_addr  <= ICARB_addr;
              ARBMC_wdata <= 32'd0;
              r_last_lsb  <= 1'b0;
            end
            G_PF: begin
              ARBMC_en    <= 1'b1;
              ARBMC_wr    <= 1'b0;
              ARBMC_len   <= BLK_BYTES;
              ARBMC_addr  <= PFARB_addr;
              ARBMC_wdata <= 32'd0;
            end
            G_LSB: begin
              ARBMC_en    <= 1'b1;
              ARBMC_wr    <= LSBARB_wr;
              ARBMC_len   <= {1'b0, LSBARB_len};
              ARBMC_addr  <= LSBARB_addr;
              ARBMC_wdata <= LSBARB_data;
              r_last_lsb  <= 1'b1;
            end
            default: ;
          endcase
        end
        S_ISSUE: begin
          if (r_tmo != TO_W'(TIMEOUT)) r_tmo <= r_tmo + TO_W'(1);
          if (r_tmo == TO_W'(TIMEOUT - 1)) ARB_err <= 1'b1;
          if (MCARB_done) begin
            ARBMC_en <= 1'b0;
            case (r_grant)
              G_IC: begin
                ARBIC_en    <= 1'b1;
                ARBIC_block <= BLK_W'(MCARB_rdata);
              end
              G_PF: begin
                ARBPF_en    <= 1'b1;
                ARBPF_block <= BLK_W'(MCARB_rdata);
              end
              G_LSB: begin
                if (ARBMC_wr) begin
                  ARBLSB_w_en <= 1'b1;
                end else begin
                  ARBLSB_r_en <= 1'b1;
                  ARBLSB_data <= lsb_bytes(ARBMC_len, MCARB_rdata);
                end
              end
              default: ;
            endcase
          end
        end
        S_RESP:  r_tmo <= '0;
        default: r_tmo <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: randomized requests against a behavioural arbitration model.
module tb_mem_req_arbiter;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst = 1'b1;
  logic        Sys_rdy = 1'b1;
  logic        ICARB_en = 1'b0;
  logic [31:0] ICARB_addr = 32'd0;
  logic        ARBIC_en;
  logic [63:0] ARBIC_block;
  logic        PFARB_en = 1'b0;
  logic [31:0] PFARB_addr = 32'd0;
  logic        ARBPF_en;
  logic [63:0] ARBPF_block;
  logic        LSBARB_en = 1'b0;
  logic        LSBARB_wr = 1'b0;
  logic [2:0]  LSBARB_len = 3'd0;
  logic [31:0] LSBARB_addr = 32'd0;
  logic [31:0] LSBARB_data = 32'd0;
  logic        ARBLSB_r_en;
  logic        ARBLSB_w_en;
  logic [31:0] ARBLSB_data;
  logic        ARBMC_en;
  logic        ARBMC_wr;
  logic [3:0]  ARBMC_len;
  logic [31:0] ARBMC_addr;
  logic [31:0] ARBMC_wdata;
  logic        MCARB_done = 1'b0;
  logic [63:0] MCARB_rdata = 64'd0;
  logic        ARB_err;

`ifdef MEM_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_req_arbiter dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .ICARB_en(ICARB_en), .ICARB_addr(ICARB_addr), .ARBIC_en(ARBIC_en), .ARBIC_block(ARBIC_block),
    .PFARB_en(PFARB_en), .PFARB_addr(PFARB_addr), .ARBPF_en(ARBPF_en), .ARBPF_block(ARBPF_block),
    .LSBARB_en(LSBARB_en), .LSBARB_wr(LSBARB_wr), .LSBARB_len(LSBARB_len),
    .LSBARB_addr(LSBARB_addr), .LSBARB_data(LSBARB_data),
    .ARBLSB_r_en(ARBLSB_r_en), .ARBLSB_w_en(ARBLSB_w_en), .ARBLSB_data(ARBLSB_data),
    .ARBMC_en(ARBMC_en), .ARBMC_wr(ARBMC_wr), .ARBMC_len(ARBMC_len),
    .ARBMC_addr(ARBMC_addr), .ARBMC_wdata(ARBMC_wdata),
    .MCARB_done(MCARB_done), .MCARB_rdata(MCARB_rdata), .ARB_err(ARB_err)
  );

  always #5 Sys_clk = ~Sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Expected LSB read data: low len bytes of the memory word.
  function automatic logic [31:0] exp_lsb(input int len, input logic [63:0] rd);
    logic [63:0] mask;
    mask = (64'd1 << (8 * len)) - 64'd1;
    return rd[31:0] & mask[31:0];
  endfunction

  function automatic logic [2:0] rand_len();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 3'd1 : (r == 1) ? 3'd2 : 3'd4;
  endfunction

  task automatic cyc();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic do_reset();
    Sys_rst = 1'b1; ICARB_en = 1'b0; PFARB_en = 1'b0; LSBARB_en = 1'b0; MCARB_done = 1'b0;
    cyc(); cyc();
    Sys_rst = 1'b0;
    cyc();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (ARBMC_en === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // Returns at the RESP-cycle sample point.
  task automatic serve(input int lat, input logic [63:0] rd);
    repeat (lat - 1) cyc();
    MCARB_done = 1'b1; MCARB_rdata = rd;
    cyc();
    MCARB_done = 1'b0;
  endtask

  task automatic test_reset();
    Sys_rst = 1'b1;
    cyc(); cyc();
    n_checks++; if ({ARBMC_en, ARBIC_en, ARBPF_en, ARBLSB_r_en, ARBLSB_w_en, ARB_err} !== 6'd0) begin
      n_fail++; $display("FAIL rst_flags: got %b expected 000000", {ARBMC_en, ARBIC_en, ARBPF_en, ARBLSB_r_en, ARBLSB_w_en, ARB_err}); end
    n_checks++; if ({ARBMC_addr, ARBMC_len, ARBMC_wdata, ARBLSB_data} !== 100'd0) begin
      n_fail++; $display("FAIL rst_data: got %h %h %h %h expected 0", ARBMC_addr, ARBMC_len, ARBMC_wdata, ARBLSB_data); end
    Sys_rst = 1'b0;
    cyc(); cyc();
    n_checks++; if (ARBMC_en !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %b expected 0", ARBMC_en); end
  endtask

  task automatic test_lsb_read();
    bit ok; int len; logic [63:0] rd; int lat; logic [31:0] exp;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin len = 2; LSBARB_addr = 32'h104; rd = {$urandom, 32'hAABBCCDD}; lat = 3; end
      else begin len = int'(rand_len()); LSBARB_addr = $urandom; rd = {$urandom, $urandom}; lat = $urandom_range(1, 5); end
      LSBARB_en = 1'b1; LSBARB_wr = 1'b0; LSBARB_len = 3'(len); LSBARB_data = $urandom;
      wait_req(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_req: got no ARBMC_en expected 1"); end
      n_checks++; if ({ARBMC_wr, ARBMC_len, ARBMC_addr} !== {1'b0, 4'(len), LSBARB_addr}) begin
        n_fail++; $display("FAIL rd_fields: got wr=%b len=%0d addr=%h expected 0 %0d %h", ARBMC_wr, ARBMC_len, ARBMC_addr, len, LSBARB_addr); end
      serve(lat, rd);
      exp = exp_lsb(len, rd);
      n_checks++; if ({ARBLSB_r_en, ARBLSB_w_en, ARBMC_en} !== 3'b100) begin
        n_fail++; $display("FAIL rd_pulse: got r=%b w=%b mc=%b expected 1 0 0", ARBLSB_r_en, ARBLSB_w_en, ARBMC_en); end
      n_checks++; if (ARBLSB_data !== exp) begin n_fail++; $display("FAIL rd_data: got %h expected %h", ARBLSB_data, exp); end
      LSBARB_en = 1'b0;
      cyc();
      n_checks++; if (ARBLSB_r_en !== 1'b0 || ARBLSB_data !== exp) begin
        n_fail++; $display("FAIL rd_hold: got r=%b data=%h expected 0 %h", ARBLSB_r_en, ARBLSB_data, exp); end
    end
  endtask

  task automatic test_lsb_write();
    bit ok; int len; logic [31:0] held;
    held = ARBLSB_data;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin len = 4; LSBARB_addr = 32'h30000; LSBARB_data = 32'h12345678; end
      else begin len = int'(rand_len()); LSBARB_addr = $urandom; LSBARB_data = $urandom; end
      LSBARB_en = 1'b1; LSBARB_wr = 1'b1; LSBARB_len = 3'(len);
      wait_req(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_req: got no ARBMC_en expected 1"); end
      n_checks++; if ({ARBMC_wr, ARBMC_len, ARBMC_addr, ARBMC_wdata} !== {1'b1, 4'(len), LSBARB_addr, LSBARB_data}) begin
        n_fail++; $display("FAIL wr_fields: got %b %0d %h %h expected 1 %0d %h %h", ARBMC_wr, ARBMC_len, ARBMC_addr, ARBMC_wdata, len, LSBARB_addr, LSBARB_data); end
      serve($urandom_range(1, 4), {$urandom, $urandom});
      n_checks++; if ({ARBLSB_w_en, ARBLSB_r_en} !== 2'b10 || ARBLSB_data !== held) begin
        n_fail++; $display("FAIL wr_pulse: got w=%b r=%b data=%h expected 1 0 %h", ARBLSB_w_en, ARBLSB_r_en, ARBLSB_data, held); end
      LSBARB_en = 1'b0;
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    bit last_lsb; bit exp_ic; logic [63:0] rd; logic [31:0] ic_addr; int len;
    do_reset();
    ic_addr = $urandom & 32'hFFFF_FFF8; len = int'(rand_len());
    ICARB_en = 1'b1; ICARB_addr = ic_addr;
    LSBARB_en = 1'b1; LSBARB_wr = 1'b0; LSBARB_len = 3'(len); LSBARB_addr = $urandom;
    last_lsb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_ic = last_lsb; last_lsb = !exp_ic;
      cyc();
      n_checks++; if (ARBMC_en !== 1'b1) begin n_fail++; $display("FAIL b2b_rise: got %b expected 1 (grant %0d)", ARBMC_en, k); end
      n_checks++; if ({ARBMC_addr, ARBMC_len} !== (exp_ic ? {ic_addr, 4'd8} : {LSBARB_addr, 4'(len)})) begin
        n_fail++; $display("FAIL b2b_who: got addr=%h len=%0d expected %s (grant %0d)", ARBMC_addr, ARBMC_len, exp_ic ? "IC" : "LSB", k); end
      rd = {$urandom, $urandom};
      serve($urandom_range(1, 4), rd);
      n_checks++; if ({ARBIC_en, ARBLSB_r_en, ARBMC_en} !== {exp_ic, !exp_ic, 1'b0}) begin
        n_fail++; $display("FAIL b2b_pulse: got ic=%b lsb=%b mc=%b expected %b %b 0", ARBIC_en, ARBLSB_r_en, ARBMC_en, exp_ic, !exp_ic); end
      n_checks++; if (exp_ic ? (ARBIC_block !== rd) : (ARBLSB_data !== exp_lsb(len, rd))) begin
        n_fail++; $display("FAIL b2b_data: got %h / %h expected from %h", ARBIC_block, ARBLSB_data, rd); end
      cyc();
      n_checks++; if ({ARBMC_en, ARBIC_en, ARBLSB_r_en} !== 3'b000) begin
        n_fail++; $display("FAIL b2b_gap: got mc=%b ic=%b lsb=%b expected 000", ARBMC_en, ARBIC_en, ARBLSB_r_en); end
    end
    ICARB_en = 1'b0; LSBARB_en = 1'b0;
    cyc();
  endtask

  task automatic test_pf_starve();
    bit ok; bit exp_pf; int age; logic [63:0] rd; logic [31:0] ic_addr; logic [31:0] pf_addr;
    do_reset();
    ic_addr = $urandom & 32'hFFFF_FFF8; pf_addr = ($urandom & 32'hFFFF_FFF8) | 32'h1;
    ICARB_en = 1'b1; ICARB_addr = ic_addr; PFARB_en = 1'b1; PFARB_addr = pf_addr;
    age = 0;
    for (int k = 0; k < 20; k++) begin
      if (AGING && age >= 4) begin exp_pf = 1'b1; age = 0; end
      else begin exp_pf = 1'b0; age++; end
      wait_req(ok);
      n_checks++; if (!ok || ARBMC_addr !== (exp_pf ? pf_addr : ic_addr)) begin
        n_fail++; $display("FAIL pf_who: got addr=%h expected %h (grant %0d)", ARBMC_addr, exp_pf ? pf_addr : ic_addr, k); end
      rd = {$urandom, $urandom};
      serve($urandom_range(1, 3), rd);
      n_checks++; if ({ARBPF_en, ARBIC_en} !== {exp_pf, !exp_pf}) begin
        n_fail++; $display("FAIL pf_pulse: got pf=%b ic=%b expected %b %b", ARBPF_en, ARBIC_en, exp_pf, !exp_pf); end
      cyc();
    end
    ICARB_en = 1'b0;
    wait_req(ok);
    n_checks++; if (!ok || {ARBMC_addr, ARBMC_len, ARBMC_wr} !== {pf_addr, 4'd8, 1'b0}) begin
      n_fail++; $display("FAIL pf_alone: got addr=%h len=%0d wr=%b expected %h 8 0", ARBMC_addr, ARBMC_len, ARBMC_wr, pf_addr); end
    rd = {$urandom, $urandom};
    serve(2, rd);
    n_checks++; if (ARBPF_en !== 1'b1 || ARBPF_block !== rd) begin
      n_fail++; $display("FAIL pf_data: got en=%b block=%h expected 1 %h", ARBPF_en, ARBPF_block, rd); end
    PFARB_en = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    bit ok; logic [63:0] rd;
    LSBARB_en = 1'b1; LSBARB_wr = 1'b0; LSBARB_len = 3'd4; LSBARB_addr = $urandom;
    wait_req(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL to_req: got no ARBMC_en expected 1"); end
    repeat (63) cyc();
    n_checks++; if (ARB_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0 at cycle 63", ARB_err); end
    cyc();
    n_checks++; if (ARB_err !== 1'b1 || ARBMC_en !== 1'b1) begin
      n_fail++; $display("FAIL to_set: got err=%b mc=%b expected 1 1 at cycle 64", ARB_err, ARBMC_en); end
    rd = {$urandom, $urandom};
    serve(6, rd);
    n_checks++; if ({ARBLSB_r_en, ARB_err} !== 2'b11 || ARBLSB_data !== rd[31:0]) begin
      n_fail++; $display("FAIL to_done: got r=%b err=%b data=%h expected 1 1 %h", ARBLSB_r_en, ARB_err, ARBLSB_data, rd[31:0]); end
    LSBARB_en = 1'b0;
    cyc();
    n_checks++; if (ARB_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", ARB_err); end
  endtask

  task automatic test_rdy_freeze();
    bit ok; logic [63:0] rd;
    Sys_rdy = 1'b0;
    LSBARB_en = 1'b1; LSBARB_wr = 1'b0; LSBARB_len = 3'd1; LSBARB_addr = $urandom;
    repeat (3) cyc();
    n_checks++; if (ARBMC_en !== 1'b0) begin n_fail++; $display("FAIL frz_idle: got %b expected 0", ARBMC_en); end
    Sys_rdy = 1'b1;
    wait_req(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frz_req: got no ARBMC_en expected 1"); end
    rd = {$urandom, $urandom};
    Sys_rdy = 1'b0; MCARB_done = 1'b1; MCARB_rdata = rd;
    repeat (3) cyc();
    n_checks++; if ({ARBMC_en, ARBLSB_r_en} !== 2'b10) begin
      n_fail++; $display("FAIL frz_issue: got mc=%b r=%b expected 1 0", ARBMC_en, ARBLSB_r_en); end
    Sys_rdy = 1'b1;
    cyc();
    MCARB_done = 1'b0;
    n_checks++; if (ARBLSB_r_en !== 1'b1 || ARBLSB_data !== exp_lsb(1, rd)) begin
      n_fail++; $display("FAIL frz_done: got r=%b data=%h expected 1 %h", ARBLSB_r_en, ARBLSB_data, exp_lsb(1, rd)); end
    LSBARB_en = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    LSBARB_en = 1'b1; LSBARB_wr = 1'b0; LSBARB_len = 3'd4; LSBARB_addr = $urandom | 32'h1;
    wait_req(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmi_req: got no ARBMC_en expected 1"); end
    #2 Sys_rst = 1'b1;
    #1;
    n_checks++; if ({ARBMC_en, ARB_err, ARBMC_len} !== 6'd0 || ARBMC_addr !== 32'd0 || ARBLSB_data !== 32'd0 || ARBIC_block !== 64'd0) begin
      n_fail++; $display("FAIL rmi_async: got mc=%b err=%b len=%0d addr=%h data=%h expected all 0", ARBMC_en, ARB_err, ARBMC_len, ARBMC_addr, ARBLSB_data); end
    LSBARB_en = 1'b0;
    cyc();
    Sys_rst = 1'b0; MCARB_done = 1'b1;
    cyc();
    MCARB_done = 1'b0;
    repeat (2) cyc();
    n_checks++; if ({ARBMC_en, ARBIC_en, ARBPF_en, ARBLSB_r_en, ARBLSB_w_en} !== 5'd0) begin
      n_fail++; $display("FAIL rmi_stale: got %b expected 00000", {ARBMC_en, ARBIC_en, ARBPF_en, ARBLSB_r_en, ARBLSB_w_en}); end
  endtask

  initial begin
    test_reset();
    test_lsb_read();
    test_lsb_write();
    test_back_to_back();
    test_pf_starve();
    test_timeout();
    test_rdy_freeze();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits between the instruction fetch path (ICache demand and ICache prefetch) and the LSB on one side, and the single-requester byte-serial memory port of the memory controller on the other.
- Picks one requester at a time and forwards its address, length and write data. Holds the grant until the memory side reports completion, then routes the result back as a one-cycle pulse.
- Guarantees the memory port only ever sees one outstanding request.

Parameters:
ADDR_WIDTH, 32, address width
BLOCK_WIDTH, 1, log2 of instructions per ICache block; a block is 4*2^BLOCK_WIDTH bytes
TIMEOUT, 64, ISSUE cycles without completion before the error flag sets
AGE_LIMIT, 4, prefetch losses before forced grant (aging build only)

Ports:
Sys_clk  in  1  clock
Sys_rst  in  1  reset; asynchronous, active-high
Sys_rdy  in  1  global enable; all state frozen when 0
ICARB_en  in  1  ICache demand request, held until ARBIC_en
ICARB_addr  in  ADDR_WIDTH  block address
ARBIC_en  out  1  one-cycle completion pulse
ARBIC_block  out  32*2^BLOCK_WIDTH  returned block
PFARB_en  in  1  prefetch request, held until ARBPF_en
PFARB_addr  in  ADDR_WIDTH  block address
ARBPF_en  out  1  one-cycle completion pulse
ARBPF_block  out  32*2^BLOCK_WIDTH  returned block
LSBARB_en  in  1  LSB request, held until ARBLSB_r_en or ARBLSB_w_en
LSBARB_wr  in  1  0 read, 1 write
LSBARB_len  in  3  byte count: 1, 2 or 4
LSBARB_addr  in  ADDR_WIDTH  byte address
LSBARB_data  in  32  write data, little-endian
ARBLSB_r_en  out  1  read-done pulse
ARBLSB_w_en  out  1  write-done pulse
ARBLSB_data  out  32  read data, zero above LSBARB_len bytes
ARBMC_en  out  1  memory request valid, held until MCARB_done
ARBMC_wr  out  1  write
ARBMC_len  out  4  byte count 1..8
ARBMC_addr  out  ADDR_WIDTH  start address
ARBMC_wdata  out  32  write data
MCARB_done  in  1  one-cycle completion from the memory side
MCARB_rdata  in  64  read bytes, byte 0 in [7:0]
ARB_err  out  1  sticky timeout flag

Behaviour:
- Reset (async): state IDLE; every output 0; last_grant=LSB; timeout and age counters 0.
- Sys_rdy=0: no state or output changes. An MCARB_done arriving in that cycle is ignored; the memory side holds it.
- FSM IDLE -> ISSUE -> RESP -> IDLE.
- IDLE, arbitration:
  - If LSBARB_en and ICARB_en are both high: grant the one not in last_grant (alternation).
  - If only one of them is high: grant it.
  - PF is granted only when both LSBARB_en and ICARB_en are low.
  - On grant: latch the winner's fields into ARBMC_*, set ARBMC_en=1 and go to ISSUE. ARBMC_en rises on the edge after the request is sampled.
  - ARBMC_len is 2^(BLOCK_WIDTH+2) for IC/PF and LSBARB_len for LSB. ARBMC_wr is 0 for IC/PF and LSBARB_wr for LSB.
  - last_grant updates only on IC or LSB grants.
- ISSUE:
  - ARBMC_* stay stable; requester inputs are ignored (no abort).
  - The timeout counter increments each cycle. On reaching TIMEOUT, set ARB_err=1 (sticky until reset) and keep waiting.
  - On MCARB_done:
    - ARBMC_en drops to 0 and the FSM goes to RESP.
    - Capture MCARB_rdata: full width to ARBIC_block or ARBPF_block. For LSB reads, bytes 0..len-1 go to ARBLSB_data and the rest are zeroed.
    - Pulse the grantee's done output high for exactly the RESP cycle.
- RESP:
  - Pulses are driven; the timeout counter clears; return to IDLE.
  - No grant happens in RESP. The requester drops en in RESP, so no request is re-served.
- Data outputs hold their last values between pulses.
- Back-to-back requests: the minimum gap between two ARBMC_en rising edges is 2 cycles after MCARB_done.
- LSBARB_len values other than 1, 2, 4 are forwarded unchanged; behaviour is otherwise undefined.
- Reset during ISSUE: immediate IDLE, no pulse issued, request lost.

Optional Feature:
MEM_ARB_AGING_EN
- Defined: a 3-bit age counter increments on each IDLE grant to IC/LSB while PFARB_en=1.
  - When the counter reaches AGE_LIMIT, the next IDLE arbitration grants PF ahead of IC/LSB and the counter clears.
  - The counter also clears on any PF grant.
- Undefined: PF is strictly lowest priority and can starve indefinitely; no counter is present.

Test Plan:
- LSB read len=2 addr 0x104, memory returns rdata 0x..AABBCCDD after 3 cycles -> ARBMC_len=2, ARBLSB_r_en one cycle, ARBLSB_data=0x0000CCDD.
- ICARB_en and LSBARB_en held high continuously with last_grant=LSB after reset -> grant order IC, LSB, IC, LSB; no pulse repeated to the same requester within RESP.
- LSB write len=4 data 0x12345678 addr 0x30000 -> ARBMC_wr=1, ARBMC_wdata=0x12345678, ARBLSB_w_en pulse, ARBLSB_r_en stays 0.
- PFARB_en high alongside continuous IC requests -> without MEM_ARB_AGING_EN no PF grant in 20 requests; with it, PF granted after 4 IC grants.
- MCARB_done withheld 64 cycles -> ARB_err=1 at cycle 64; done at cycle 70 completes normally and ARB_err stays 1.
- Sys_rst asserted mid-ISSUE -> all outputs 0 asynchronously; after release, no stale pulse appears.
